odometer_seq_ctrl: RTL

- Autonomous stress/measure sequencer for the odometer aging sensor and its VCO.
- Replaces hand-driven RESETB/LOAD/START/AC_DC/SEL_*/MEAS_TRIG/CLK_KILL/EN_VCO stimulus.
- Runs N rounds of stress-then-measure over a mask of structures (INV, NAND, NOR) and returns one BF_COUNT result per structure per round.
- Sits between the chip config/scan registers and odometer_full_rvt/VCO_full.

---
 rtl/odometer_seq_pkg.sv | 69 ++++++
 rtl/odometer_seq_timer.sv | 28 ++
 rtl/odometer_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/odometer_seq_pkg.sv
// Shared types and helpers for the odometer stress/measure sequencer.
package odometer_seq_pkg;

    localparam int BF_W = 12;

    localparam logic [1:0] SEL_IDX_INV  = 2'd0;
    localparam logic [1:0] SEL_IDX_NAND = 2'd1;
    localparam logic [1:0] SEL_IDX_NOR  = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ODO_RST,
        ST_CONFIG,
        ST_LOAD_ST,
        ST_STRESS,
        ST_MEAS,
        ST_SETTLE,
        ST_CAPTURE,
        ST_NEXT,
        ST_FIN
    } state_t;

    typedef struct packed {
        logic       resetb;
        logic       load;
        logic       start;
        logic       ac_dc;
        logic [2:0] sel;
        logic       meas_trig;
        logic       en_vco;
        logic       clk_kill;
        logic       busy;
    } ctl_t;

    localparam ctl_t CTL_RESET = '{resetb: 1'b0, load: 1'b0, start: 1'b0, ac_dc: 1'b0,
                                   sel: 3'b000, meas_trig: 1'b1, en_vco: 1'b0,
                                   clk_kill: 1'b0, busy: 1'b0};

    localparam ctl_t CTL_IDLE = '{resetb: 1'b1, load: 1'b0, start: 1'b0, ac_dc: 1'b0,
                                  sel: 3'b000, meas_trig: 1'b1, en_vco: 1'b0,
                                  clk_kill: 1'b0, busy: 1'b0};

    localparam ctl_t CTL_ODO_RST = '{resetb: 1'b0, load: 1'b0, start: 1'b0, ac_dc: 1'b0,
                                     sel: 3'b000, meas_trig: 1'b1, en_vco: 1'b1,
                                     clk_kill: 1'b0, busy: 1'b1};

    function automatic logic [2:0] sel_onehot(input logic [1:0] idx);
        case (idx)
            SEL_IDX_INV:  sel_onehot = 3'b001;
            SEL_IDX_NAND: sel_onehot = 3'b010;
            SEL_IDX_NOR:  sel_onehot = 3'b100;
            default:      sel_onehot = 3'b000;
        endcase
    endfunction

    // True when any mask bit at index >= from is set.
    function automatic logic any_at(input logic [2:0] mask, input logic [1:0] from);
        any_at = 1'b0;
        for (int i = 0; i < 3; i++)
            if (mask[i] && i >= int'(from)) any_at = 1'b1;
    endfunction

    function automatic logic [1:0] lowest_at(input logic [2:0] mask, input logic [1:0] from);
        lowest_at = 2'd0;
        for (int i = 2; i >= 0; i--)
            if (mask[i] && i >= int'(from)) lowest_at = 2'(i);
    endfunction

endpackage

// File: rtl/odometer_seq_timer.sv
// Loadable down-counter shared by every timed phase of the sequencer.
module odometer_seq_timer
    import odometer_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/odometer_seq_ctrl.sv
// Autonomous stress/measure sequencer driving the odometer sensor and its VCO.
// Define ODO_DELTA_EN to add per-structure baselines and the RES_DELTA output.
module odometer_seq_ctrl
    import odometer_seq_pkg::*;
#(
    parameter int STRESS_W   = 16,
    parameter int RST_CYC    = 4,
    parameter int MEAS_CYC   = 8,
    parameter int SETTLE_CYC = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   GO,
    input  logic                   ABORT,
    input  logic [2:0]             CFG_MASK,
    input  logic                   CFG_AC_DC,
    input  logic [1:0]             CFG_DIV,
    input  logic [STRESS_W-1:0]    CFG_STRESS_CYC,
    input  logic [7:0]             CFG_REPEAT,
    input  logic [BF_W-1:0]        BF_COUNT,
    output logic                   RESETB,
    output logic                   LOAD,
    output logic                   START,
    output logic                   AC_DC,
    output logic                   SEL_INV,
    output logic                   SEL_NAND,
    output logic                   SEL_NOR,
    output logic                   MEAS_TRIG,
    output logic                   EN_VCO,
    output logic                   CLK_KILL,
    output logic [1:0]             VCO_DIV_SEL,
    output logic                   RES_VALID,
    output logic [BF_W-1:0]        RES_COUNT,
    output logic [1:0]             RES_SEL,
    output logic [7:0]             RES_ROUND,
    output logic                   BUSY,
`ifdef ODO_DELTA_EN
    output logic signed [BF_W:0]   RES_DELTA,
`endif
    output logic                   DONE
);

    localparam int TW = (STRESS_W > 8) ? STRESS_W : 8;

    state_t               state;
    ctl_t                 ctl;
    logic [1:0]           idx;
    logic [7:0]           round;
    logic [2:0]           sh_mask;
    logic                 sh_ac_dc;
    logic [STRESS_W-1:0]  sh_stress;
    logic [7:0]           sh_repeat;

    logic                 tmr_load;
    logic                 tmr_en;
    logic [TW-1:0]        tmr_val;
    logic                 tmr_zero;

    odometer_seq_timer #(.W(TW)) u_timer (
        .clk      (CLK),
        .rst      (RESET),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    // Each timed phase is loaded with N-1 on entry so it lasts exactly N cycles.
    always_comb begin
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: begin
                if (GO && !ABORT && CFG_MASK != 3'b000) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(RST_CYC - 1);
                end
            end
            ST_LOAD_ST: begin
                tmr_load = 1'b1;
                tmr_val  = (sh_stress != '0) ? TW'(sh_stress) - TW'(1) : TW'(MEAS_CYC - 1);
            end
            ST_STRESS: begin
                tmr_load = tmr_zero;
                tmr_en   = !tmr_zero;
                tmr_val  = TW'(MEAS_CYC - 1);
            end
            ST_MEAS: begin
                tmr_load = tmr_zero;
                tmr_en   = !tmr_zero;
                tmr_val  = TW'(SETTLE_CYC - 1);
            end
            ST_ODO_RST, ST_SETTLE: tmr_en = !tmr_zero;
            default: ;
        endcase
    end

    function automatic ctl_t enter_config(input ctl_t c, input logic [1:0] i, input logic ac);
        ctl_t r;
        r           = c;
        r.resetb    = 1'b1;
        r.sel       = sel_onehot(i);
        r.ac_dc     = ac;
        r.load      = 1'b0;
        r.start     = 1'b0;
        r.meas_trig = 1'b1;
        r.clk_kill  = 1'b0;
        return r;
    endfunction

`ifdef ODO_DELTA_EN
    logic [BF_W-1:0] base_inv, base_nand, base_nor;
    logic [BF_W-1:0] cur_base;

    always_comb begin
        case (idx)
            SEL_IDX_NAND: cur_base = base_nand;
            SEL_IDX_NOR:  cur_base = base_nor;
            default:      cur_base = base_inv;
        endcase
    end
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            ctl         <= CTL_RESET;
            VCO_DIV_SEL <= '0;
            DONE        <= 1'b0;
            RES_VALID   <= 1'b0;
            RES_COUNT   <= '0;
            RES_SEL     <= '0;
            RES_ROUND   <= '0;
            idx         <= SEL_IDX_INV;
            round       <= '0;
`ifdef ODO_DELTA_EN
            RES_DELTA   <= '0;
`endif
        end else begin
            DONE      <= 1'b0;
            RES_VALID <= 1'b0;
            if (ABORT && state != ST_IDLE) begin
                state       <= ST_IDLE;
                ctl         <= CTL_IDLE;
                VCO_DIV_SEL <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        ctl         <= CTL_IDLE;
                        VCO_DIV_SEL <= '0;
                        if (GO && !ABORT) begin
                            sh_mask   <= CFG_MASK;
                            sh_ac_dc  <= CFG_AC_DC;
                            sh_stress <= CFG_STRESS_CYC;
                            sh_repeat <= (CFG_REPEAT == 8'd0) ? 8'd1 : CFG_REPEAT;
                            round     <= '0;
                            idx       <= lowest_at(CFG_MASK, 2'd0);
                            if (CFG_MASK == 3'b000) begin
                                state <= ST_FIN;
                                DONE  <= 1'b1;
                            end else begin
                                state       <= ST_ODO_RST;
                                ctl         <= CTL_ODO_RST;
                                VCO_DIV_SEL <= CFG_DIV;
                            end
                        end
                    end
                    ST_ODO_RST: begin
                        if (tmr_zero) begin
                            state <= ST_CONFIG;
                            ctl   <= enter_config(ctl, idx, sh_ac_dc);
                        end
                    end
                    ST_CONFIG: begin
                        state    <= ST_LOAD_ST;
                        ctl.load <= 1'b1;
                    end
                    ST_LOAD_ST: begin
                        if (sh_stress != '0) begin
                            state         <= ST_STRESS;
                            ctl.start     <= 1'b1;
                            ctl.meas_trig <= 1'b1;
                            ctl.clk_kill  <= 1'b0;
                        end else begin
                            state         <= ST_MEAS;
                            ctl.start     <= 1'b0;
                            ctl.clk_kill  <= 1'b1;
                            ctl.meas_trig <= 1'b0;
                        end
                    end
                    ST_STRESS: begin
                        if (tmr_zero) begin
                            state         <= ST_MEAS;
                            ctl.start     <= 1'b0;
                            ctl.clk_kill  <= 1'b1;
                            ctl.meas_trig <= 1'b0;
                        end
                    end
                    ST_MEAS: begin
                        if (tmr_zero) begin
                            state         <= ST_SETTLE;
                            ctl.meas_trig <= 1'b1;
                            ctl.clk_kill  <= 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (tmr_zero) begin
                            state        <= ST_CAPTURE;
                            ctl.clk_kill <= 1'b0;
                        end
                    end
                    ST_CAPTURE: begin
                        state     <= ST_NEXT;
                        ctl.load  <= 1'b0;
                        RES_COUNT <= BF_COUNT;
                        RES_SEL   <= idx;
                        RES_ROUND <= round;
                        RES_VALID <= 1'b1;
`ifdef ODO_DELTA_EN
                        if (round == 8'd0) begin
                            RES_DELTA <= '0;
                            case (idx)
                                SEL_IDX_NAND: base_nand <= BF_COUNT;
                                SEL_IDX_NOR:  base_nor  <= BF_COUNT;
                                default:      base_inv  <= BF_COUNT;
                            endcase
                        end else begin
                            RES_DELTA <= $signed({1'b0, BF_COUNT}) - $signed({1'b0, cur_base});
                        end
`endif
                    end
                    ST_NEXT: begin
                        if (any_at(sh_mask, idx + 2'd1)) begin
                            state <= ST_CONFIG;
                            idx   <= lowest_at(sh_mask, idx + 2'd1);
                            ctl   <= enter_config(ctl, lowest_at(sh_mask, idx + 2'd1), sh_ac_dc);
                        end else if (round + 8'd1 == sh_repeat) begin
                            state       <= ST_FIN;
                            round       <= round + 8'd1;
                            ctl         <= CTL_IDLE;
                            VCO_DIV_SEL <= '0;
                            DONE        <= 1'b1;
                        end else begin
                            state <= ST_CONFIG;
                            round <= round + 8'd1;
                            idx   <= lowest_at(sh_mask, 2'd0);
                            ctl   <= enter_config(ctl, lowest_at(sh_mask, 2'd0), sh_ac_dc);
                        end
                    end
                    ST_FIN: begin
                        state <= ST_IDLE;
                        ctl   <= CTL_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        ctl   <= CTL_IDLE;
                    end
                endcase
            end
        end
    end

    assign RESETB    = ctl.resetb;
    assign LOAD      = ctl.load;
    assign START     = ctl.start;
    assign AC_DC     = ctl.ac_dc;
    assign SEL_INV   = ctl.sel[SEL_IDX_INV];
    assign SEL_NAND  = ctl.sel[SEL_IDX_NAND];
    assign SEL_NOR   = ctl.sel[SEL_IDX_NOR];
    assign MEAS_TRIG = ctl.meas_trig;
    assign EN_VCO    = ctl.en_vco;
    assign CLK_KILL  = ctl.clk_kill;
    assign BUSY      = ctl.busy;

endmodule
